count_frame_check: RTL
======================

# count_frame_check

Receive-side companion to the cycle-count tagger. It consumes a stream whose beats carry a 16-bit cycle count and a final-count flag, and checks that the counts run 0..cnt_limit without gaps. It converts the final-count flag into AXI-Stream tlast and drops beats until it regains alignment after an error. It sits downstream of the tagger's output FIFO, in front of framed consumers such as packetizers and DMA.

## Interface
- DATA_WIDTH, 32, payload width in bits
- clk  in  1  clock
- sync_reset  in  1  synchronous reset, active-high
- cnt_limit  in  16  last count value of a frame; must be held static while s_axis_tvalid is high
- s_axis_tvalid  in  1  input beat valid
- s_axis_tdata  in  DATA_WIDTH  input payload
- s_axis_count  in  16  cycle count tag of the beat
- s_axis_final_cnt  in  1  tagger's final-count flag
- s_axis_tready  out  1  input ready; registered
- m_axis_tvalid  out  1  output beat valid
- m_axis_tdata  out  DATA_WIDTH  output payload
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  output ready
- locked  out  1  high while in LOCKED
- seq_err  out  1  one-cycle pulse per erroneous accepted beat
- err_cnt  out  16  saturating count of errors

## Operation
- A beat is accepted when s_axis_tvalid & s_axis_tready.
- The FSM has two states: HUNT (reset state) and LOCKED. It holds an expected-count register `exp` of 16 bits.
- HUNT:
  - Accepted beat with count != 0: discarded, no error raised.
  - Accepted beat with count == 0: forwarded; state → LOCKED.
- LOCKED, accepted beat is good when count == exp AND final_cnt == (count == cnt_limit):
  - The beat is forwarded with tlast = (count == cnt_limit).
  - exp ← 0 if count == cnt_limit, else count+1.
- LOCKED, accepted beat is bad (either condition fails):
  - seq_err pulses and err_cnt increments, saturating at 0xFFFF.
  - If count == 0 and final_cnt == (0 == cnt_limit), the beat is treated as a resync: it is forwarded, the state stays LOCKED, and exp is set as for a good beat.
  - Otherwise the beat is dropped and the state → HUNT.
- Whenever a beat is forwarded with count == 0: exp ← 1, or exp ← 0 if cnt_limit == 0. When cnt_limit == 0, every forwarded beat carries tlast.
- Count arithmetic is 16-bit. count == 0xFFFF with cnt_limit == 0xFFFF wraps exp to 0. Any count > cnt_limit is bad.
- Dropped beats never reach m_axis. Forwarded beats are never reordered.

## Timing
- Reset values: s_axis_tready 0 during reset and 1 from the first cycle after; m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0; locked 0; seq_err 0; err_cnt 0; exp 0; state HUNT.
- A reset mid-frame discards the skid contents and any in-flight beat.
- Check latency: the check runs in the acceptance cycle. seq_err and locked update on the next clock edge.
- Data latency: an accepted, forwarded beat appears on m_axis one cycle after acceptance, provided the output register is empty or being drained that cycle.
- Output buffering is a 2-entry skid buffer.
  - s_axis_tready is registered and equals "skid entry empty".
  - The block sustains one beat per clock with m_axis_tready held high.
  - Deasserting m_axis_tready stalls within one beat with no loss.
- m_axis_tvalid, tdata and tlast are held stable while m_axis_tvalid & !m_axis_tready (AXI rule).
- Dropped beats are accepted at full rate regardless of m_axis_tready, as long as s_axis_tready is high.

## Structure
- Package count_frame_pkg holds:
  - state enum {HUNT, LOCKED}
  - CNT_W = 16
  - ERR_MAX = 16'hFFFF
- Sub-module axi_skid_buf (parameter DATA_WIDTH+1, carrying tdata and tlast) implements the output register and skid.
- The top level holds the FSM, exp, the comparators and err_cnt.

## Test plan
- cnt_limit=3, input counts 0,1,2,3,0,1,2,3 with final_cnt set on the 3s, m_axis_tready=1 → 8 beats out, tlast on beats 4 and 8; seq_err never pulses; locked=1 from the cycle after the first beat.
- Start mid-frame, cnt_limit=3, counts 2,3,0,1,2,3 → first 2 beats dropped; 4 beats forwarded with tlast on the last; err_cnt=0.
- LOCKED with cnt_limit=3, counts 0,1,3,0,1 → the count-3 beat is dropped and seq_err pulses once; HUNT, then relock on the 0; output is 0,1,0,1; err_cnt=1.
- Flag error: cnt_limit=3, count 3 arrives with final_cnt=0 → seq_err; beat dropped; state HUNT.
- Backpressure: random m_axis_tready at 50% duty over 1000 beats with cnt_limit=255 → output sequence identical to input, no loss, data stable under stall; cnt_limit=0 case → every beat has tlast.
- Assert sync_reset mid-frame while m_axis is stalled → m_axis_tvalid=0 and err_cnt=0 the next cycle; block in HUNT; the next count-0 beat relocks.

Source files
------------

// File: rtl/count_frame_pkg.sv
// Shared types and constants for the count-tagged frame checker.
package count_frame_pkg;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] ERR_MAX = 16'hFFFF;

   typedef enum logic {HUNT, LOCKED} state_t;

   // Count expected after forwarding a beat: a frame's last count restarts at zero.
   function automatic logic [CNT_W-1:0] next_exp(input logic [CNT_W-1:0] count,
                                                  input logic             is_last);
      return is_last ? '0 : count + 16'd1;
   endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry AXI-Stream skid buffer: an output register plus one skid slot, registered in_ready.
module axi_skid_buf #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             load_out;
   logic             skid_valid_nxt;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      load_out       = !out_valid || out_ready;
      skid_valid_nxt = skid_valid;
      if (load_out) skid_valid_nxt = 1'b0;
      else if (in_valid) skid_valid_nxt = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         if (load_out) begin
            if (skid_valid) begin
               out_valid <= 1'b1;
               out_data  <= skid_data;
            end else begin
               out_valid <= in_valid;
               if (in_valid) out_data <= in_data;
            end
         end
         skid_valid <= skid_valid_nxt;
         in_ready   <= !skid_valid_nxt;
      end
   end

   // NOTE: skid payload is storage qualified by skid_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!load_out && in_valid && !skid_valid) skid_data <= in_data;
   end

endmodule

// File: rtl/count_frame_check.sv
// Checks 0..cnt_limit count sequencing on a tagged stream and reframes it with tlast.
module count_frame_check
   import count_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic [CNT_W-1:0]      cnt_limit,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CNT_W-1:0]      s_axis_count,
   input  logic                  s_axis_final_cnt,
   output logic                  s_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  locked,
   output logic                  seq_err,
   output logic [CNT_W-1:0]      err_cnt
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   exp_cnt, exp_nxt;
   logic               accept, is_last, flag_ok, resync_ok;
   logic               fwd, bad;
   logic [DATA_WIDTH:0] out_word;

   assign accept    = s_axis_tvalid && s_axis_tready;
   assign is_last   = (s_axis_count == cnt_limit);
   assign flag_ok   = (s_axis_final_cnt == is_last);
   // A count-0 beat with a consistent flag restarts the frame even after an error.
   assign resync_ok = (s_axis_count == '0) && (s_axis_final_cnt == (cnt_limit == '0));

   always_comb begin
      state_nxt = state;
      exp_nxt   = exp_cnt;
      fwd       = 1'b0;
      bad       = 1'b0;
      if (accept) begin
         case (state)
            HUNT: begin
               if (s_axis_count == '0) begin
                  fwd       = 1'b1;
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if ((s_axis_count == exp_cnt) && flag_ok) begin
                  fwd = 1'b1;
               end else begin
                  bad = 1'b1;
                  if (resync_ok) fwd = 1'b1;
                  else state_nxt = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
      if (fwd) exp_nxt = next_exp(s_axis_count, is_last);
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state   <= HUNT;
         exp_cnt <= '0;
         seq_err <= 1'b0;
         err_cnt <= '0;
      end else begin
         state   <= state_nxt;
         exp_cnt <= exp_nxt;
         seq_err <= bad;
         if (bad && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 16'd1;
      end
   end

   assign locked = (state == LOCKED);

   axi_skid_buf #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .sync_reset(sync_reset),
      .in_valid  (fwd),
      .in_data   ({is_last, s_axis_tdata}),
      .in_ready  (s_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (out_word),
      .out_ready (m_axis_tready)
   );

   assign m_axis_tdata = out_word[DATA_WIDTH-1:0];
   assign m_axis_tlast = out_word[DATA_WIDTH];

endmodule
